// File: rtl/console_pkg.sv
`default_nettype none
// ============================================================================
// console_pkg
// Shared types, ASCII/ANSI constants and escape-sequence byte helpers.
// Revision: 1.0
// ============================================================================
package console_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREFIX = 2'd1,
        ST_BODY   = 2'd2,
        ST_SUFFIX = 2'd3
    } state_t;

    localparam logic [7:0] ESC         = 8'h1B;
    localparam logic [7:0] CSI_BRACKET = 8'h5B;
    localparam logic [7:0] SEMI        = 8'h3B;
    localparam logic [7:0] CHAR_M      = 8'h6D;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_3     = 8'h33;

    localparam logic [2:0] RED    = 3'd1;
    localparam logic [2:0] GREEN  = 3'd2;
    localparam logic [2:0] YELLOW = 3'd3;
    localparam logic [2:0] BLUE   = 3'd4;
    localparam logic [2:0] PURPLE = 3'd5;
    localparam logic [2:0] CYAN   = 3'd6;
    localparam logic [2:0] WHITE  = 3'd7;

    localparam logic [2:0] PREFIX_LAST = 3'd6;
    localparam logic [2:0] SUFFIX_LAST = 3'd3;

    // "ESC[<bold>;3<color>m" one byte at a time
    function automatic logic [7:0] prefix_byte(input logic [2:0] idx,
                                               input logic       bold,
                                               input logic [2:0] color);
        logic [7:0] b;
        case (idx)
            3'd0:    b = ESC;
            3'd1:    b = CSI_BRACKET;
            3'd2:    b = ASCII_0 + {7'b0, bold};
            3'd3:    b = SEMI;
            3'd4:    b = ASCII_3;
            3'd5:    b = ASCII_0 + {5'b0, color};
            default: b = CHAR_M;
        endcase
        return b;
    endfunction

    // "ESC[0m"
    function automatic logic [7:0] suffix_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = ESC;
            2'd1:    b = CSI_BRACKET;
            2'd2:    b = ASCII_0;
            default: b = CHAR_M;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/console_color_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Revision: 1.0
// ============================================================================
module rr_arbiter
    import console_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx
);

    int w_cand;

    // Scan offsets high-to-low so the smallest offset from ptr wins last.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = '0;
        w_cand    = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_cand = (int'(ptr) + off) % NUM_REQ;
            if (req[w_cand[IDX_W-1:0]]) begin
                gnt_idx = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/console_color_arbiter.sv
`default_nettype none
// ============================================================================
// console_color_arbiter
// Round-robin message arbiter onto one byte console, with optional ANSI color.
// Revision: 1.0
// ============================================================================
module console_color_arbiter
    import console_pkg::*;
#(
    parameter int          NUM_REQ   = 4,
    parameter logic [31:0] REQ_COLOR = 32'h0000_4321,
    parameter int          CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       color_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [CNT_W-1:0]           msg_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             r_state;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [2:0]         r_idx;
    logic               r_color_lat;
    logic               r_busy;
    logic [CNT_W-1:0]   r_msg_count;

    logic               w_arb_valid;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_sel_valid;
    logic [7:0]         w_sel_data;
    logic               w_sel_last;
    logic [3:0]         w_cfg;
    logic               w_body_fire;
    logic               w_done;
    logic [IDX_W-1:0]   w_next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .gnt_valid (w_arb_valid),
        .gnt_idx   (w_arb_idx)
    );

    assign w_sel_valid = req_valid[r_grant];
    assign w_sel_data  = req_data[{r_grant, 3'b000} +: 8];
    assign w_sel_last  = req_last[r_grant];
    assign w_cfg       = REQ_COLOR[{r_grant, 2'b00} +: 4];
    assign w_body_fire = (r_state == ST_BODY) && w_sel_valid && out_ready;
    assign w_next_ptr  = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);

    // Message completes on the final body byte (uncolored) or final suffix byte.
    assign w_done = (w_body_fire && w_sel_last && !r_color_lat) ||
                    ((r_state == ST_SUFFIX) && out_ready && (r_idx == SUFFIX_LAST));

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        req_ready = '0;
        case (r_state)
            ST_PREFIX: begin
                out_valid = 1'b1;
                out_data  = prefix_byte(r_idx, w_cfg[3], w_cfg[2:0]);
            end
            ST_BODY: begin
                out_valid          = w_sel_valid;
                out_data           = w_sel_data;
                req_ready[r_grant] = out_ready;
            end
            ST_SUFFIX: begin
                out_valid = 1'b1;
                out_data  = suffix_byte(r_idx[1:0]);
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_idx       <= '0;
            r_color_lat <= 1'b0;
            r_busy      <= 1'b0;
            r_msg_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant     <= w_arb_idx;
                        r_color_lat <= color_en;
                        r_busy      <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= color_en ? ST_PREFIX : ST_BODY;
                    end
                end
                ST_PREFIX: begin
                    if (out_ready) begin
                        if (r_idx == PREFIX_LAST) begin
                            r_idx   <= '0;
                            r_state <= ST_BODY;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                ST_BODY: begin
                    if (w_body_fire && w_sel_last && r_color_lat) begin
                        r_idx   <= '0;
                        r_state <= ST_SUFFIX;
                    end
                end
                ST_SUFFIX: begin
                    if (out_ready && (r_idx != SUFFIX_LAST)) begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_done) begin
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_idx       <= '0;
                r_rr_ptr    <= w_next_ptr;
                r_msg_count <= r_msg_count + CNT_W'(1);
            end
        end
    end

    assign grant_id  = r_grant;
    assign busy      = r_busy;
    assign msg_count = r_msg_count;

endmodule
`default_nettype wire
